// File: rtl/gate_alu_pkg.sv
// rtl/gate_alu_pkg.sv - op encoding shared by the gate ALU and its op decoder
package gate_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASB = 3'b111
  } op_e;

endpackage

// File: rtl/gate_op.sv
// rtl/gate_op.sv - combinational bitwise operator selected by a 3-bit op code
module gate_op
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      OP_PASB: result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/gate_alu.sv
// rtl/gate_alu.sv - two-stage bitwise ALU with valid/ready handshake and accumulator
module gate_alu
  import gate_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] r1_q, r1_d, y_q, y_d, acc_q, acc_d;
  logic             zero_q, zero_d, parity_q, parity_d;
  logic             s1_rdy, s2_rdy, accept, use_acc;
  logic [WIDTH-1:0] a_eff, result_c;

  assign s2_rdy   = !v2_q || out_ready;
  assign s1_rdy   = !v1_q || s2_rdy;
  assign in_ready = s1_rdy;
  assign accept   = in_valid && s1_rdy;

  // A same-cycle clear makes the beat see a zero accumulator, so no bubble is needed.
  assign use_acc = (ACC_EN != 0) && acc_mode;
  assign a_eff   = use_acc ? (acc_clr ? '0 : acc_q) : a;

  gate_op #(.WIDTH(WIDTH)) u_gate_op (
    .op     (op),
    .a      (a_eff),
    .b      (b),
    .result (result_c)
  );

  always_comb begin
    v1_d     = v1_q;
    r1_d     = r1_q;
    v2_d     = v2_q;
    y_d      = y_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    acc_d    = acc_q;
    if (s1_rdy) begin
      v1_d = accept;
      if (accept) r1_d = result_c;
    end
    if (s2_rdy) begin
      v2_d = v1_q;
      if (v1_q) begin
        y_d      = r1_q;
        zero_d   = ~|r1_q;
        parity_d = ^r1_q;
      end
    end
    if (ACC_EN != 0) begin
      if (accept && acc_mode) acc_d = result_c;
      else if (acc_clr)       acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      r1_q     <= '0;
      v2_q     <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      r1_q     <= r1_d;
      v2_q     <= v2_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = v2_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_gate_alu.sv
// tb/tb_gate_alu.sv - directed vector bench for gate_alu at WIDTH=8
module tb_gate_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] op;
  logic       acc_mode, acc_clr;
  logic [7:0] a, b;
  logic       out_valid, out_ready;
  logic [7:0] y;
  logic       zero, parity;

  int checks = 0;
  int errors = 0;

  gate_alu #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       mode;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
    logic       p;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic m, input logic c,
                       input logic [7:0] av, input logic [7:0] bv);
    in_valid = v;
    op       = o;
    acc_mode = m;
    acc_clr  = c;
    a        = av;
    b        = bv;
  endtask

  logic [7:0] bp_vals [4];
  logic       exp_ir  [4];
  int         sent, rcv;
  logic       ir, ov;
  logic [7:0] yy;

  initial begin
    // ops on F0/3C, flag pair, then the accumulate chain (clear rides on the flag beat)
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{3'b001, 1'b0, 1'b0, 8'hAA, 8'h01, 8'hAB, 1'b0, 1'b1};
    vecs[10] = '{3'b001, 1'b1, 1'b0, 8'h55, 8'h01, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{3'b001, 1'b1, 1'b0, 8'h55, 8'h02, 8'h03, 1'b0, 1'b0};
    vecs[12] = '{3'b001, 1'b1, 1'b0, 8'h55, 8'h04, 8'h07, 1'b0, 1'b1};
    vecs[13] = '{3'b010, 1'b1, 1'b0, 8'h55, 8'hFF, 8'hF8, 1'b0, 1'b1};
    vecs[14] = '{3'b001, 1'b1, 1'b1, 8'h55, 8'h10, 8'h10, 1'b0, 1'b1};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset y", y, 8'h00);
    chk("reset zero", zero, 1);
    chk("reset parity", parity, 0);
    chk("reset in_ready", in_ready, 1);

    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("vec%0d out_valid", i - 2), out_valid, 1);
        chk($sformatf("vec%0d y", i - 2), y, vecs[i-2].y);
        chk($sformatf("vec%0d zero", i - 2), zero, vecs[i-2].z);
        chk($sformatf("vec%0d parity", i - 2), parity, vecs[i-2].p);
      end else begin
        chk($sformatf("lead%0d out_valid", i), out_valid, 0);
      end
      if (i < NV)
        drive(1'b1, vecs[i].op, vecs[i].mode, vecs[i].clr, vecs[i].a, vecs[i].b);
      else
        drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
    end
    chk("drained out_valid", out_valid, 0);

    // Backpressure: stall output for four cycles, then release
    bp_vals[0] = 8'h11; bp_vals[1] = 8'h22; bp_vals[2] = 8'h33; bp_vals[3] = 8'h44;
    exp_ir[0] = 1'b1; exp_ir[1] = 1'b1; exp_ir[2] = 1'b0; exp_ir[3] = 1'b0;
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      out_ready = (cyc >= 4);
      if (sent < 4) drive(1'b1, 3'b111, 1'b0, 1'b0, 8'h00, bp_vals[sent]);
      else          drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      ir = in_ready;
      ov = out_valid;
      yy = y;
      if (cyc < 4) chk($sformatf("bp in_ready c%0d", cyc), ir, exp_ir[cyc]);
      if (cyc >= 2 && cyc < 4) begin
        chk($sformatf("bp hold valid c%0d", cyc), ov, 1);
        chk($sformatf("bp hold y c%0d", cyc), yy, 8'h11);
      end
      @(posedge clk);
      if (in_valid && ir) sent++;
      if (ov && out_ready) begin
        if (rcv < 4) chk($sformatf("bp order %0d", rcv), yy, bp_vals[rcv]);
        rcv++;
      end
      @(negedge clk);
    end
    chk("bp received count", rcv, 4);
    chk("bp sent count", sent, 4);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-flight with both stages loaded and a nonzero accumulator
    drive(1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 8'h5A);
    @(negedge clk);
    drive(1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 8'h0F);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_clr = 1'b0;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst y", y, 8'h00);
    chk("midrst zero", zero, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst no stale %0d", k), out_valid, 0);
    end

    // Acc must be zero: OR with b=00 gives 00; check exact 2-cycle latency
    drive(1'b1, 3'b001, 1'b1, 1'b0, 8'h77, 8'h00);
    @(negedge clk);
    drive(1'b1, 3'b111, 1'b1, 1'b0, 8'h77, 8'h00);
    chk("lat cycle1 out_valid", out_valid, 0);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("lat cycle2 out_valid", out_valid, 1);
    chk("post-rst acc OR y", y, 8'h00);
    chk("post-rst acc zero", zero, 1);
    @(negedge clk);
    chk("post-rst pass out_valid", out_valid, 1);
    chk("post-rst pass y", y, 8'h00);
    @(negedge clk);
    chk("final idle out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
